// File: rtl/if_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_ctrl_if
// Brief   : Hazard, instruction-memory, IF/ID and counter bundle of the IF stage.
// Revision: 1.0
// ============================================================================
interface if_stage_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             stall_i;
  logic             flush_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      imem_addr_o;
  logic [31:0]      imem_data_i;
  logic [31:0]      if_id_pc_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic             halt_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic [CNT_W-1:0] cycle_cnt_o;

  // Fetch stage side.
  modport slave (
    input  stall_i, flush_i, branch_target_i, imem_data_i,
    output imem_addr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, halt_o,
           stall_cnt_o, flush_cnt_o, cycle_cnt_o
  );

  // Hazard unit / memory / observer side.
  modport master (
    output stall_i, flush_i, branch_target_i, imem_data_i,
    input  imem_addr_o, if_id_pc_o, if_id_instr_o, if_id_valid_o, halt_o,
           stall_cnt_o, flush_cnt_o, cycle_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_stage_ctrl
// Brief   : RISC-V IF stage: PC, IF/ID latch, ebreak drain-and-halt, perf counters.
// Revision: 1.0
// ============================================================================
module if_stage_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          DRAIN_CYCLES = 4,
  parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
  parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073,
  parameter int          CNT_W        = 32
) (
  input  wire logic       clk_i,
  input  wire logic       rst_i,
  if_stage_ctrl_if.slave  bus
);

  localparam logic [3:0] c_drain_init = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_DRAIN  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_if_id_pc;
  logic [31:0]      r_if_id_instr;
  logic             r_if_id_valid;
  logic             r_halt;
  logic [3:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;

  logic [31:0]      w_target;

  // Redirects are always word aligned.
  assign w_target = bus.branch_target_i & ~32'h3;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= S_RUN;
      r_pc          <= RESET_PC;
      r_if_id_pc    <= 32'h0;
      r_if_id_instr <= NOP_INSTR;
      r_if_id_valid <= 1'b0;
      r_halt        <= 1'b0;
      r_drain_cnt   <= 4'h0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
      r_cycle_cnt   <= '0;
    end else if (r_state != S_HALTED) begin
      r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (bus.flush_i) begin
        // A flush during drain means the ebreak was on the wrong path.
        r_pc          <= w_target;
        r_if_id_pc    <= 32'h0;
        r_if_id_instr <= NOP_INSTR;
        r_if_id_valid <= 1'b0;
        r_flush_cnt   <= r_flush_cnt + 1'b1;
        r_state       <= S_RUN;
      end else if (bus.stall_i) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end else begin
        r_pc       <= r_pc + 32'd4;
        r_if_id_pc <= r_pc;
        if (r_state == S_RUN) begin
          r_if_id_instr <= bus.imem_data_i;
          r_if_id_valid <= 1'b1;
          if (bus.imem_data_i == EBREAK_INSTR) begin
            r_drain_cnt <= c_drain_init;
            r_state     <= S_DRAIN;
          end
        end else begin
          r_if_id_instr <= NOP_INSTR;
          r_if_id_valid <= 1'b0;
          r_drain_cnt   <= r_drain_cnt - 4'd1;
          if (r_drain_cnt == 4'd1) begin
            r_state <= S_HALTED;
            r_halt  <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.imem_addr_o   = r_pc;
  assign bus.if_id_pc_o    = r_if_id_pc;
  assign bus.if_id_instr_o = r_if_id_instr;
  assign bus.if_id_valid_o = r_if_id_valid;
  assign bus.halt_o        = r_halt;
  assign bus.stall_cnt_o   = r_stall_cnt;
  assign bus.flush_cnt_o   = r_flush_cnt;
  assign bus.cycle_cnt_o   = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_if_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_stage_ctrl
// Brief   : Self-checking bench for if_stage_ctrl: reference model plus directed scenarios.
// Revision: 1.0
// ============================================================================
module tb_if_stage_ctrl;

  localparam logic [31:0] c_nop    = 32'h0000_0013;
  localparam logic [31:0] c_ebreak = 32'h0010_0073;
  localparam int          c_drain  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_ctrl_if #(.CNT_W(32)) bus ();

  if_stage_ctrl #(
    .RESET_PC    (32'h0),
    .DRAIN_CYCLES(c_drain),
    .NOP_INSTR   (c_nop),
    .EBREAK_INSTR(c_ebreak),
    .CNT_W       (32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  logic [31:0] mem [64];
  assign bus.imem_data_i = mem[bus.imem_addr_o[7:2]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: plain program-order view of fetch; bubbles_left > 0 means draining.
  logic [31:0] m_pc, m_ifpc, m_instr, m_stall, m_flush, m_cyc;
  logic        m_valid, m_halt, m_known;
  int          bubbles_left;
  logic [31:0] word;
  initial m_known = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_pc = 0; m_ifpc = 0; m_instr = c_nop; m_valid = 0; m_halt = 0;
      m_stall = 0; m_flush = 0; m_cyc = 0; bubbles_left = 0; m_known = 1'b1;
    end else if (m_known && !m_halt) begin
      m_cyc = m_cyc + 1;
      if (bus.flush_i) begin
        m_pc = {bus.branch_target_i[31:2], 2'b00};
        m_ifpc = 0; m_instr = c_nop; m_valid = 0;
        m_flush = m_flush + 1; bubbles_left = 0;
      end else if (bus.stall_i) begin
        m_stall = m_stall + 1;
      end else if (bubbles_left > 0) begin
        m_ifpc = m_pc; m_instr = c_nop; m_valid = 0;
        m_pc = m_pc + 4;
        bubbles_left--;
        if (bubbles_left == 0) m_halt = 1;
      end else begin
        word = mem[m_pc[7:2]];
        m_ifpc = m_pc; m_instr = word; m_valid = 1;
        m_pc = m_pc + 4;
        if (word == c_ebreak) bubbles_left = c_drain;
      end
    end
    #1;
    if (m_known) begin
      chk("cmp_pc",    bus.imem_addr_o,           m_pc);
      chk("cmp_ifpc",  bus.if_id_pc_o,            m_ifpc);
      chk("cmp_instr", bus.if_id_instr_o,         m_instr);
      chk("cmp_valid", {31'h0, bus.if_id_valid_o}, {31'h0, m_valid});
      chk("cmp_halt",  {31'h0, bus.halt_o},        {31'h0, m_halt});
      chk("cmp_stall", bus.stall_cnt_o,           m_stall);
      chk("cmp_flush", bus.flush_cnt_o,           m_flush);
      chk("cmp_cyc",   bus.cycle_cnt_o,           m_cyc);
    end
  end

  // Advance n edges; inputs and literal checks happen 2 time units after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = c_nop;
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.branch_target_i = 32'h0;

    // 1: reset state and plain fetch
    do_reset();
    chk("rst_pc",    bus.imem_addr_o, 32'h0);
    chk("rst_instr", bus.if_id_instr_o, c_nop);
    chk("rst_valid", {31'h0, bus.if_id_valid_o}, 32'h0);
    chk("rst_cyc",   bus.cycle_cnt_o, 32'h0);
    step(5);
    chk("t1_pc",    bus.imem_addr_o, 32'd20);
    chk("t1_ifpc",  bus.if_id_pc_o, 32'd16);
    chk("t1_valid", {31'h0, bus.if_id_valid_o}, 32'h1);
    chk("t1_cyc",   bus.cycle_cnt_o, 32'd5);
    chk("t1_stall", bus.stall_cnt_o, 32'd0);

    // 2: stall holds PC and IF/ID
    do_reset();
    step(2);
    bus.stall_i = 1'b1;
    step(2);
    chk("t2_pc_hold",   bus.imem_addr_o, 32'd8);
    chk("t2_ifpc_hold", bus.if_id_pc_o, 32'd4);
    chk("t2_stall_cnt", bus.stall_cnt_o, 32'd2);
    bus.stall_i = 1'b0;
    step(1);
    chk("t2_pc_rel", bus.imem_addr_o, 32'd12);

    // 3: flush beats stall, target gets aligned
    bus.stall_i = 1'b1; bus.flush_i = 1'b1; bus.branch_target_i = 32'h43;
    step(1);
    bus.stall_i = 1'b0; bus.flush_i = 1'b0;
    chk("t3_pc",    bus.imem_addr_o, 32'h40);
    chk("t3_instr", bus.if_id_instr_o, c_nop);
    chk("t3_valid", {31'h0, bus.if_id_valid_o}, 32'h0);
    chk("t3_flush", bus.flush_cnt_o, 32'd1);
    chk("t3_stall", bus.stall_cnt_o, 32'd2);

    // 4: ebreak at 12 drains then halts
    mem[3] = c_ebreak;
    do_reset();
    step(4);
    chk("t4_instr", bus.if_id_instr_o, c_ebreak);
    chk("t4_ifpc",  bus.if_id_pc_o, 32'd12);
    step(3);
    chk("t4_nohalt", {31'h0, bus.halt_o}, 32'h0);
    chk("t4_pc28",   bus.imem_addr_o, 32'd28);
    step(1);
    chk("t4_halt", {31'h0, bus.halt_o}, 32'h1);
    chk("t4_pc32", bus.imem_addr_o, 32'd32);
    chk("t4_cyc",  bus.cycle_cnt_o, 32'd8);
    bus.flush_i = 1'b1; bus.branch_target_i = 32'h0;
    step(3);
    bus.flush_i = 1'b0;
    chk("t4_frozen_pc",  bus.imem_addr_o, 32'd32);
    chk("t4_frozen_cyc", bus.cycle_cnt_o, 32'd8);
    chk("t4_frozen_fl",  bus.flush_cnt_o, 32'd0);

    // 5: wrong-path ebreak cancelled by flush; ebreak under stall/flush not latched
    do_reset();
    step(5);
    bus.flush_i = 1'b1; bus.branch_target_i = 32'h0;
    step(1);
    bus.flush_i = 1'b0;
    chk("t5_pc0", bus.imem_addr_o, 32'd0);
    step(3);
    bus.stall_i = 1'b1;
    step(1);
    bus.stall_i = 1'b0;
    bus.flush_i = 1'b1; bus.branch_target_i = 32'h40;
    step(1);
    bus.flush_i = 1'b0;
    step(6);
    chk("t5_nohalt", {31'h0, bus.halt_o}, 32'h0);
    chk("t5_pc",     bus.imem_addr_o, 32'h58);
    chk("t5_valid",  {31'h0, bus.if_id_valid_o}, 32'h1);

    // 6: reset out of HALTED
    do_reset();
    step(8);
    chk("t6_halted", {31'h0, bus.halt_o}, 32'h1);
    do_reset();
    chk("t6_pc",    bus.imem_addr_o, 32'h0);
    chk("t6_halt",  {31'h0, bus.halt_o}, 32'h0);
    chk("t6_cyc",   bus.cycle_cnt_o, 32'h0);
    chk("t6_valid", {31'h0, bus.if_id_valid_o}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
